// File: rtl/mp3_ui_pkg.sv
// Shared types for the MP3 player UI controller: command codes, FSM states,
// button indices and the command bundle driven onto the decoder port.
package mp3_ui_pkg;

    localparam int NUM_BTNS     = 4;
    // Index order doubles as service priority: lower index wins.
    localparam int BTN_NEXT     = 0;
    localparam int BTN_PRE      = 1;
    localparam int BTN_VOL_PLUS = 2;
    localparam int BTN_VOL_DEC  = 3;

    typedef enum logic {
        CMD_LOAD_TRACK = 1'b0,
        CMD_SET_VOL    = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT_TRK,
        ST_INIT_VOL,
        ST_IDLE,
        ST_ISSUE
    } state_e;

    typedef struct packed {
        cmd_e       op;
        logic [7:0] arg;
    } cmd_t;

endpackage

// File: rtl/btn_debounce.sv
// One front-panel button: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int             CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_d <= level;
            // Count only while the input disagrees with the accepted level.
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/mp3_ui_ctrl.sv
// Player-control scheduler: debounced buttons -> pending flags -> one-at-a-time
// valid/ready decoder commands, plus vsync-latched track/volume display shadows.
module mp3_ui_ctrl
    import mp3_ui_pkg::*;
#(
    parameter int N_TRACKS   = 4,
    parameter int VOL_MAX    = 15,
    parameter int VOL_INIT   = 8,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_next,
    input  logic       i_pre,
    input  logic       i_vol_plus,
    input  logic       i_vol_dec,
    input  logic       i_vs,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic       o_cmd,
    output logic [7:0] o_cmd_arg,
    output logic [7:0] o_track,
    output logic [3:0] o_vol,
    output logic       o_busy
);

    localparam int            TW       = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1;
    localparam logic [TW-1:0] TRK_LAST = TW'(N_TRACKS - 1);
    localparam logic [3:0]    VMAX     = 4'(VOL_MAX);
    localparam logic [3:0]    VINIT    = 4'(VOL_INIT);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_rise;
    logic [NUM_BTNS-1:0] pend;
    logic [NUM_BTNS-1:0] pend_clr;

    state_e        state, state_n;
    cmd_t          cmd_q, cmd_n;
    logic          vld_q, vld_n;
    logic [TW-1:0] track_q, track_n;
    logic [3:0]    vol_q, vol_n;
    logic          hs;

    logic [1:0]    vs_sync;
    logic          vs_d;
    logic          vs_fall;

    assign btn_raw = {i_vol_dec, i_vol_plus, i_pre, i_next};

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTNS-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw),
        .rise  (btn_rise)
    );

    assign hs = vld_q & i_cmd_ready;

    always_comb begin
        state_n  = state;
        vld_n    = vld_q;
        cmd_n    = cmd_q;
        track_n  = track_q;
        vol_n    = vol_q;
        pend_clr = '0;
        unique case (state)
            ST_INIT_TRK: begin
                if (hs) begin
                    vld_n   = 1'b0;
                    state_n = ST_INIT_VOL;
                end else if (!vld_q) begin
                    vld_n = 1'b1;
                    cmd_n = '{op: CMD_LOAD_TRACK, arg: 8'd0};
                end
            end
            ST_INIT_VOL: begin
                if (hs) begin
                    vld_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (!vld_q) begin
                    vld_n = 1'b1;
                    cmd_n = '{op: CMD_SET_VOL, arg: {4'd0, VINIT}};
                end
            end
            ST_IDLE: begin
                if (pend[BTN_NEXT]) begin
                    pend_clr[BTN_NEXT] = 1'b1;
                    track_n = (track_q == TRK_LAST) ? '0 : track_q + 1'b1;
                    cmd_n   = '{op: CMD_LOAD_TRACK, arg: 8'(track_n)};
                    vld_n   = 1'b1;
                    state_n = ST_ISSUE;
                end else if (pend[BTN_PRE]) begin
                    pend_clr[BTN_PRE] = 1'b1;
                    track_n = (track_q == '0) ? TRK_LAST : track_q - 1'b1;
                    cmd_n   = '{op: CMD_LOAD_TRACK, arg: 8'(track_n)};
                    vld_n   = 1'b1;
                    state_n = ST_ISSUE;
                end else if (pend[BTN_VOL_PLUS]) begin
                    // At the limit the press is consumed silently.
                    pend_clr[BTN_VOL_PLUS] = 1'b1;
                    if (vol_q != VMAX) begin
                        vol_n   = vol_q + 4'd1;
                        cmd_n   = '{op: CMD_SET_VOL, arg: {4'd0, vol_n}};
                        vld_n   = 1'b1;
                        state_n = ST_ISSUE;
                    end
                end else if (pend[BTN_VOL_DEC]) begin
                    pend_clr[BTN_VOL_DEC] = 1'b1;
                    if (vol_q != 4'd0) begin
                        vol_n   = vol_q - 4'd1;
                        cmd_n   = '{op: CMD_SET_VOL, arg: {4'd0, vol_n}};
                        vld_n   = 1'b1;
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (hs) begin
                    vld_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_INIT_TRK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_INIT_TRK;
            vld_q   <= 1'b0;
            cmd_q   <= '{op: CMD_LOAD_TRACK, arg: 8'd0};
            track_q <= '0;
            vol_q   <= VINIT;
            pend    <= '0;
        end else begin
            state   <= state_n;
            vld_q   <= vld_n;
            cmd_q   <= cmd_n;
            track_q <= track_n;
            vol_q   <= vol_n;
            // A press landing in its own service cycle is kept, not lost.
            pend    <= (pend & ~pend_clr) | btn_rise;
        end
    end

    // Vsync idles high, so resetting the synchroniser high avoids a false edge.
    assign vs_fall = vs_d & ~vs_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_sync <= 2'b11;
            vs_d    <= 1'b1;
            o_track <= '0;
            o_vol   <= VINIT;
        end else begin
            vs_sync <= {vs_sync[0], i_vs};
            vs_d    <= vs_sync[1];
            if (vs_fall) begin
                o_track <= 8'(track_q);
                o_vol   <= vol_q;
            end
        end
    end

    assign o_cmd_valid = vld_q;
    assign o_cmd       = cmd_q.op;
    assign o_cmd_arg   = cmd_q.arg;
    assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mp3_ui_ctrl.sv
// Randomised bench for mp3_ui_ctrl against a queue-based player model.
module tb_mp3_ui_ctrl;

    localparam int N_TRACKS = 4;
    localparam int VOL_MAX  = 15;
    localparam int VOL_INIT = 8;
    localparam int DEB      = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_next = 1'b0, i_pre = 1'b0, i_vol_plus = 1'b0, i_vol_dec = 1'b0;
    logic       i_vs = 1'b1;
    logic       i_cmd_ready = 1'b1;
    logic       o_cmd_valid, o_cmd, o_busy;
    logic [7:0] o_cmd_arg, o_track;
    logic [3:0] o_vol;

    int checks = 0, failures = 0;
    int trk, vol, disp_trk, disp_vol, n_valid;
    logic [8:0] exp_q[$];
    bit   mon_en = 1'b0, rdy_rand = 1'b0, rdy_fix = 1'b1;
    logic p_vld = 1'b0, p_rdy = 1'b0, p_cmd = 1'b0;
    logic [7:0] p_arg = '0;

    mp3_ui_ctrl #(.N_TRACKS(N_TRACKS), .VOL_MAX(VOL_MAX), .VOL_INIT(VOL_INIT),
                  .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .i_next(i_next), .i_pre(i_pre),
        .i_vol_plus(i_vol_plus), .i_vol_dec(i_vol_dec), .i_vs(i_vs),
        .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd(o_cmd),
        .o_cmd_arg(o_cmd_arg), .o_track(o_track), .o_vol(o_vol), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Player model: what a single serviced press does to track/vol and the command stream.
    task automatic model_btn(input int b);
        case (b)
            0: begin trk = (trk + 1) % N_TRACKS; exp_q.push_back({1'b0, 8'(trk)}); end
            1: begin trk = (trk + N_TRACKS - 1) % N_TRACKS; exp_q.push_back({1'b0, 8'(trk)}); end
            2: if (vol < VOL_MAX) begin vol++; exp_q.push_back({1'b1, 8'(vol)}); end
            default: if (vol > 0) begin vol--; exp_q.push_back({1'b1, 8'(vol)}); end
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || o_busy || o_cmd_valid) && t < 400) begin
            cyc(1);
            t++;
        end
        cyc(2);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", o_busy, 0);
    endtask

    task automatic press(input logic [3:0] m);
        {i_vol_dec, i_vol_plus, i_pre, i_next} = m;
        for (int b = 0; b < 4; b++) if (m[b]) model_btn(b);
        cyc(8);
        {i_vol_dec, i_vol_plus, i_pre, i_next} = 4'b0;
        cyc(8);
        drain();
    endtask

    task automatic vs_pulse();
        i_vs = 1'b0;
        cyc(3);
        i_vs = 1'b1;
        cyc(4);
        disp_trk = trk;
        disp_vol = vol;
    endtask

    // Ready driver: random back-pressure or a fixed level chosen by the stimulus.
    initial forever begin
        @(posedge clk);
        #2;
        i_cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end

    // Protocol monitor: hold-while-stalled, valid gap after transfer, in-order payloads.
    always @(negedge clk) begin
        if (o_cmd_valid) n_valid++;
        if (mon_en) begin
            if (p_vld && !p_rdy) begin
                chk("hold_valid", o_cmd_valid, 1);
                chk("hold_payload", {o_cmd, o_cmd_arg}, {p_cmd, p_arg});
            end
            if (p_vld && p_rdy) chk("gap_after_xfer", o_cmd_valid, 0);
            if (o_cmd_valid && i_cmd_ready) begin
                if (exp_q.size() == 0) chk("unexpected_cmd", {o_cmd, o_cmd_arg}, 9'h1ff);
                else chk("cmd_payload", {o_cmd, o_cmd_arg}, exp_q.pop_front());
            end
        end
        p_vld = o_cmd_valid;
        p_rdy = i_cmd_ready;
        p_cmd = o_cmd;
        p_arg = o_cmd_arg;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] held;
        int t;
        trk = 0; vol = VOL_INIT; disp_trk = 0; disp_vol = VOL_INIT; n_valid = 0;
        cyc(3);
        chk("rst_valid", o_cmd_valid, 0);
        chk("rst_payload", {o_cmd, o_cmd_arg}, 0);
        chk("rst_track", o_track, 0);
        chk("rst_vol", o_vol, VOL_INIT);
        chk("rst_busy", o_busy, 1);

        // Init sequence with ready held high.
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b1, 8'(VOL_INIT)});
        n_valid = 0;
        mon_en = 1'b1;
        rst_n = 1'b1;
        drain();
        chk("init_valid_cycles", n_valid, 2);
        chk("init_track", o_track, 0);
        chk("init_vol", o_vol, VOL_INIT);

        // Track wrap forward and backward.
        repeat (4) press(4'b0001);
        vs_pulse();
        chk("wrap_track", o_track, trk);
        press(4'b0010);
        vs_pulse();
        chk("pre_wrap_track", o_track, trk);

        // Volume saturation at both ends.
        repeat (8) press(4'b0100);
        vs_pulse();
        chk("vol_sat_hi", o_vol, vol);
        repeat (16) press(4'b1000);
        vs_pulse();
        chk("vol_sat_lo", o_vol, vol);

        // Simultaneous next + vol_plus: priority order and gap come from the monitor.
        press(4'b0101);

        // Random button sets under random back-pressure.
        rdy_rand = 1'b1;
        repeat (40) begin
            press(4'($urandom_range(1, 15)));
            if ($urandom_range(0, 1) == 1) begin
                vs_pulse();
                chk("rnd_track", o_track, trk);
                chk("rnd_vol", o_vol, vol);
            end
        end
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        cyc(2);

        // Glitch shorter than the debounce window.
        n_valid = 0;
        i_next = 1'b1;
        cyc(3);
        i_next = 1'b0;
        cyc(20);
        chk("glitch_no_cmd", n_valid, 0);
        chk("glitch_busy", o_busy, 0);

        // Display only follows vsync.
        press(4'b0001);
        chk("midframe_hold", o_track, disp_trk);
        vs_pulse();
        chk("midframe_update", o_track, trk);

        // Stall in ISSUE, then reset mid-handshake.
        rdy_fix = 1'b0;
        cyc(1);
        i_next = 1'b1;
        model_btn(0);
        cyc(8);
        i_next = 1'b0;
        t = 0;
        while (!o_cmd_valid && t < 30) begin cyc(1); t++; end
        chk("stall_valid_seen", o_cmd_valid, 1);
        held = {o_cmd_valid, o_cmd, o_cmd_arg};
        repeat (20) begin
            cyc(1);
            chk("stall_hold", {o_cmd_valid, o_cmd, o_cmd_arg}, held);
        end
        mon_en = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        chk("rst_drop_valid", o_cmd_valid, 0);
        exp_q.delete();
        trk = 0; vol = VOL_INIT; disp_trk = 0; disp_vol = VOL_INIT;
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b1, 8'(VOL_INIT)});
        rdy_fix = 1'b1;
        n_valid = 0;
        rst_n = 1'b1;
        cyc(1);
        mon_en = 1'b1;
        drain();
        chk("replay_valid_cycles", n_valid, 2);
        chk("replay_track", o_track, disp_trk);
        chk("replay_vol", o_vol, disp_vol);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
